// File: rtl/memory_pkg.sv
// Shared constants and helpers for the VeriRISC instruction/data memory.
// Optional feature macro: MEMORY_PARITY_EN (per-word even parity + par_err).
package memory_pkg;

    localparam int MEM_AWIDTH = 5;
    localparam int MEM_DWIDTH = 8;

    // Number of words addressed by an address of the given width.
    function automatic int mem_depth(input int awidth);
        return 1 << awidth;
    endfunction

    // Even-parity bit of a word: XOR of all data bits (callers zero-extend).
    function automatic logic parity_of(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/memory_if.sv
// Control/address bundle between the VeriRISC controller and its memory.
// The shared data bus is a plain inout on the memory so the tristate
// resolution stays between two module ports.
interface memory_if
    import memory_pkg::*;
#(
    parameter int AWIDTH = MEM_AWIDTH
);
    logic              wr;
    logic              rd;
    logic [AWIDTH-1:0] addr;

    modport master (output wr, output rd, output addr);
    modport slave  (input  wr, input  rd, input  addr);
endinterface

// File: rtl/memory.sv
// Single-port RAM: synchronous write, combinational read onto a shared
// tristate data bus, asynchronous active-low clear of every word.
// Optional feature macro: MEMORY_PARITY_EN adds a stored even-parity bit
// per word and a combinational par_err output.
module memory
    import memory_pkg::*;
#(
    parameter int AWIDTH = MEM_AWIDTH,
    parameter int DWIDTH = MEM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_,
    memory_if.slave           bus,
    inout  wire  [DWIDTH-1:0] data
`ifdef MEMORY_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int DEPTH = mem_depth(AWIDTH);

    // Write wins over read; the bus is only driven on a pure read so a
    // controller asserting both never fights the memory for the bus.
    logic read_en;
    assign read_en = bus.rd & ~bus.wr;

    logic [DWIDTH-1:0] words [DEPTH];

`ifdef MEMORY_PARITY_EN
    logic [DEPTH-1:0] parity_bits;
`endif

    // Each word is its own register so the whole array can clear
    // asynchronously; only the addressed word loads on a write.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DWIDTH-1:0] word_reg;

        // Clear on reset, capture the bus when this word is written.
        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                word_reg <= '0;
            end else if (bus.wr && (bus.addr == AWIDTH'(gi))) begin
                word_reg <= data;
            end
        end

        assign words[gi] = word_reg;

`ifdef MEMORY_PARITY_EN
        // Parity kept in a separate flop so it can be corrupted on its own.
        logic parity_reg;

        // Store the parity of the incoming word alongside it.
        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                parity_reg <= 1'b0;
            end else if (bus.wr && (bus.addr == AWIDTH'(gi))) begin
                parity_reg <= parity_of(64'(data));
            end
        end

        assign parity_bits[gi] = parity_reg;
`endif
    end

    // Drive the addressed word only during a pure read, else release.
    assign data = read_en ? words[bus.addr] : {DWIDTH{1'bz}};

`ifdef MEMORY_PARITY_EN
    // Flag a word whose stored parity disagrees with its stored data.
    always_comb begin
        par_err = 1'b0;
        if (read_en) begin
            par_err = parity_bits[bus.addr] != parity_of(64'(words[bus.addr]));
        end
    end
`endif

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed scenarios followed by random
// reads, writes, collisions, idles and reset pulses checked against an
// array model of the RAM contents.
module tb_memory;
    import memory_pkg::*;

    logic clk;
    logic rst_;
    logic       tb_drive_en;
    logic [7:0] tb_data;
    wire  [7:0] data;
`ifdef MEMORY_PARITY_EN
    logic par_err;
`endif

    memory_if mif ();

    assign data = tb_drive_en ? tb_data : 8'hzz;

    memory dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (mif.slave),
        .data (data)
`ifdef MEMORY_PARITY_EN
        ,
        .par_err (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared;
    int n_mismatched;
    logic [7:0] model [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
    endtask

    // One write transaction: wr=1, rd=0, bench drives the bus over a posedge.
    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        mif.addr = a; mif.wr = 1'b1; mif.rd = 1'b0;
        tb_data = d; tb_drive_en = 1'b1;
        @(posedge clk);
        #1;
        if (rst_) model[a] = d;
        mif.wr = 1'b0; tb_drive_en = 1'b0;
    endtask

    // One read transaction: bus released, rd=1, sample mid-phase.
    task automatic read_check(input logic [4:0] a, input string tag);
        @(negedge clk);
        mif.addr = a; mif.wr = 1'b0; mif.rd = 1'b1; tb_drive_en = 1'b0;
        #2;
        check(tag, 32'(data), 32'(model[a]));
`ifdef MEMORY_PARITY_EN
        check({tag, "_par"}, 32'(par_err), 32'd0);
`endif
    endtask

    // rd=1 wr=1: the bench owns the bus and the memory must stay off it.
    task automatic collide(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        mif.addr = a; mif.wr = 1'b1; mif.rd = 1'b1;
        tb_data = d; tb_drive_en = 1'b1;
        #2;
        check("collide_bus", 32'(data), 32'(d));
        @(posedge clk);
        #1;
        if (rst_) model[a] = d;
        mif.wr = 1'b0; mif.rd = 1'b0; tb_drive_en = 1'b0;
    endtask

    // Idle with the bench driving: the memory must have released the bus.
    task automatic idle_drive(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        mif.addr = a; mif.wr = 1'b0; mif.rd = 1'b0;
        tb_data = d; tb_drive_en = 1'b1;
        #2;
        check("idle_bus", 32'(data), 32'(d));
        tb_drive_en = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst_ = 1'b0;
        model_clear();
        #1;
        rst_ = 1'b1;
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        rst_ = 1'b1;
        mif.wr = 1'b0; mif.rd = 1'b0; mif.addr = '0;
        tb_drive_en = 1'b0; tb_data = 8'h00;
        model_clear();

        // Reset state: every word reads 0 while rst_ is low.
        #3;
        rst_ = 1'b0;
        mif.rd = 1'b1;
        for (int i = 0; i < 32; i += 9) begin
            mif.addr = 5'(i);
            #1;
            check("reset_read", 32'(data), 32'h0);
        end
        @(negedge clk);
        rst_ = 1'b1;

        // Fill addr 31..1 with 0..30, then read back in the same order.
        for (int i = 0; i < 31; i++) do_write(5'(31 - i), 8'(i));
        for (int i = 0; i < 31; i++) begin
            read_check(5'(31 - i), "fill_read");
            check("fill_value", 32'(data), 32'(i));
        end

        // Bus release, then a read with no clock edge in between.
        do_write(5'd3, 8'hA5);
        idle_drive(5'd3, 8'h5A);
        mif.rd = 1'b1;
        #1;
        check("release_then_read", 32'(data), 32'hA5);

        // Asynchronous reset mid-cycle wipes addr 7 immediately.
        do_write(5'd7, 8'h3C);
        @(posedge clk);
        #2;
        rst_ = 1'b0;
        model_clear();
        mif.addr = 5'd7; mif.rd = 1'b1; mif.wr = 1'b0;
        #1;
        check("async_reset_read", 32'(data), 32'h00);
        // Write attempted across an edge while reset is held.
        mif.rd = 1'b0; mif.wr = 1'b1; tb_data = 8'h77; tb_drive_en = 1'b1;
        @(posedge clk);
        #1;
        mif.wr = 1'b0; tb_drive_en = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        read_check(5'd7, "write_in_reset");
        read_check(5'd3, "reset_cleared_3");

        // Write/read collision on addr 9 holding a different value.
        do_write(5'd9, 8'hAA);
        collide(5'd9, 8'h55);
        read_check(5'd9, "after_collide");

        // Address change during a read updates the bus in the same phase.
        do_write(5'd2, 8'h11);
        do_write(5'd4, 8'h22);
        @(negedge clk);
        mif.rd = 1'b1; mif.wr = 1'b0; mif.addr = 5'd2;
        #1;
        check("addr_chg_first", 32'(data), 32'h11);
        mif.addr = 5'd4;
        #1;
        check("addr_chg_second", 32'(data), 32'h22);

`ifdef MEMORY_PARITY_EN
        // Parity: clean word, then a corrupted stored parity bit.
        do_write(5'd5, 8'h07);
        read_check(5'd5, "parity_clean");
        force dut.g_word[5].parity_reg = 1'b0;
        #1;
        check("parity_forced_rd", 32'(par_err), 32'd1);
        mif.rd = 1'b0;
        #1;
        check("parity_forced_idle", 32'(par_err), 32'd0);
        release dut.g_word[5].parity_reg;
`endif

        // Random traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] ra;
            logic [7:0] rdv;
            int op;
            ra  = 5'($urandom_range(0, 31));
            rdv = 8'($urandom_range(0, 255));
            op  = int'($urandom_range(0, 9));
            if (op < 4)       do_write(ra, rdv);
            else if (op < 8)  read_check(ra, "rand_read");
            else if (op == 8) collide(ra, rdv);
            else if ($urandom_range(0, 3) == 0) reset_pulse();
            else              idle_drive(ra, rdv);
        end

        // Final sweep of the whole array.
        for (int i = 0; i < 32; i++) read_check(5'(i), "final_sweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
